// File: rtl/frame_shift_engine.sv
// ============================================================================
// Module   : frame_shift_engine
// Purpose  : Full-duplex serial shift engine for Hamming codewords. A parallel
//            word is loaded, shifted out bit-serially, and WIDTH serial input
//            bits are captured into the same register during the same frame.
//            Frame control provides a start/ready handshake, a bit counter,
//            abort, and a one-cycle done pulse.
// Optional : FRAME_PARITY_EN - appends a parity bit to each frame and reports
//            a receive parity mismatch on parity_err.
// Ports    : clk          in   clock, rising edge
//            rest         in   asynchronous reset, active-high
//            start        in   load parallel_in (accepted only when ready)
//            abort        in   cancel the frame in progress
//            shift_en     in   bit strobe, one bit per strobed edge
//            parallel_in  in   word to transmit
//            serial_in    in   received serial bit
//            serial_out   out  current transmit bit
//            parallel_out out  shift register contents / received word
//            ready        out  engine idle
//            busy         out  frame in progress
//            done         out  one-cycle frame-complete pulse
//            bit_cnt      out  data bits shifted in the current frame
//            parity_err   out  received parity mismatch, valid with done
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_shift_engine #(
  parameter int WIDTH     = 15,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic             abort,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             parity_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] shifted;
  logic             tx_bit;
  logic             last_bit;

  // The edge that moves the final data bit.
  assign last_bit     = (bit_cnt == CNT_W'(WIDTH - 1));
  assign parallel_out = data;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {data[WIDTH-2:0], serial_in};
      assign tx_bit  = data[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted = {serial_in, data[WIDTH-1:1]};
      assign tx_bit  = data[0];
    end
  endgenerate

`ifdef FRAME_PARITY_EN
  logic tx_par;

  // During the parity slot the line carries the parity of the loaded word.
  assign serial_out = (state == S_PAR) ? tx_par : tx_bit;
`else
  assign serial_out = tx_bit;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state   <= S_IDLE;
      data    <= '0;
      bit_cnt <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef FRAME_PARITY_EN
      tx_par     <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            data    <= parallel_in;
            bit_cnt <= '0;
            state   <= S_SHIFT;
            ready   <= 1'b0;
            busy    <= 1'b1;
`ifdef FRAME_PARITY_EN
            tx_par     <= ^parallel_in;
            parity_err <= 1'b0;
`endif
          end
        end

        S_SHIFT: begin
          if (abort) begin
            data    <= '0;
            bit_cnt <= '0;
            state   <= S_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
`ifdef FRAME_PARITY_EN
            parity_err <= 1'b0;
`endif
          end else if (shift_en) begin
            data    <= shifted;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
`ifdef FRAME_PARITY_EN
              state <= S_PAR;
`else
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end
          end
        end

`ifdef FRAME_PARITY_EN
        S_PAR: begin
          if (abort) begin
            data       <= '0;
            bit_cnt    <= '0;
            state      <= S_IDLE;
            ready      <= 1'b1;
            busy       <= 1'b0;
            parity_err <= 1'b0;
          end else if (shift_en) begin
            // The received parity bit is compared against the captured word
            // directly; it is not needed after this edge.
            parity_err <= serial_in ^ (^data);
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_shift_engine.sv
// ============================================================================
// Module   : tb_frame_shift_engine
// Purpose  : Self-checking bench for frame_shift_engine. One LSB-first and one
//            MSB-first instance share the control inputs; each has its own
//            serial input (loopback, constant, or loopback with the parity
//            slot inverted). A frame-level model predicts every output.
// Optional : FRAME_PARITY_EN - enables the parity-slot scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_shift_engine;

  localparam int WIDTH = 15;
  localparam int CW    = 4;
`ifdef FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Strobed edges from the START edge to the DONE state.
  localparam int FL = WIDTH + PAR;

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_BUSY = 2'd1;
  localparam logic [1:0] M_DONE = 2'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, abort, shift_en;
  logic [WIDTH-1:0] pin;
  logic [1:0]       si, so, rdy, bsy, dn, pe;
  logic [WIDTH-1:0] po  [2];
  logic [CW-1:0]    cnt [2];
  logic [1:0]       lb, cv;
  logic             flip;

  // Frame-level model: transmitted word, bits received so far (bit i is the
  // i-th received bit), bits moved, word held while idle.
  logic [1:0]       m_st   [2];
  logic [WIDTH-1:0] m_tx   [2];
  logic [WIDTH-1:0] m_rx   [2];
  logic [WIDTH-1:0] m_hold [2];
  int               m_cnt  [2];
  logic             m_pe   [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_en  = 1'b0;

  assign si[0] = lb[0] ? (so[0] ^ (flip & (m_st[0] == M_BUSY) & (m_cnt[0] == WIDTH))) : cv[0];
  assign si[1] = lb[1] ? (so[1] ^ (flip & (m_st[1] == M_BUSY) & (m_cnt[1] == WIDTH))) : cv[1];

  frame_shift_engine #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rest(rst), .start(start), .abort(abort), .shift_en(shift_en),
    .parallel_in(pin), .serial_in(si[0]), .serial_out(so[0]),
    .parallel_out(po[0]), .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
    .bit_cnt(cnt[0]), .parity_err(pe[0])
  );

  frame_shift_engine #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rest(rst), .start(start), .abort(abort), .shift_en(shift_en),
    .parallel_in(pin), .serial_in(si[1]), .serial_out(so[1]),
    .parallel_out(po[1]), .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
    .bit_cnt(cnt[1]), .parity_err(pe[1])
  );

  // Expected register image: the not-yet-sent part of the word plus the
  // bits received so far, placed by shift direction.
  function automatic logic [WIDTH-1:0] exp_po(input int d);
    logic [WIDTH-1:0] r;
    int c;
    if (m_st[d] == M_IDLE) return m_hold[d];
    c = (m_cnt[d] > WIDTH) ? WIDTH : m_cnt[d];
    r = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (d == 0) begin
        if (k < WIDTH - c) r[k] = m_tx[d][k + c];
        else               r[k] = m_rx[d][k - (WIDTH - c)];
      end else begin
        if (k >= c) r[k] = m_tx[d][k - c];
        else        r[k] = m_rx[d][c - 1 - k];
      end
    end
    return r;
  endfunction

  function automatic logic exp_so(input int d);
    logic [WIDTH-1:0] p;
    if (m_st[d] == M_BUSY && m_cnt[d] == WIDTH) return ^m_tx[d];
    p = exp_po(d);
    return (d == 0) ? p[0] : p[WIDTH-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_st[d]   <= M_IDLE;
        m_tx[d]   <= '0;
        m_rx[d]   <= '0;
        m_hold[d] <= '0;
        m_cnt[d]  <= 0;
        m_pe[d]   <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        case (m_st[d])
          M_IDLE: begin
            if (start && !abort) begin
              m_tx[d]  <= pin;
              m_rx[d]  <= '0;
              m_cnt[d] <= 0;
              m_pe[d]  <= 1'b0;
              m_st[d]  <= M_BUSY;
            end
          end
          M_BUSY: begin
            if (abort) begin
              m_st[d]   <= M_IDLE;
              m_hold[d] <= '0;
              m_cnt[d]  <= 0;
              m_pe[d]   <= 1'b0;
            end else if (shift_en) begin
              if (m_cnt[d] < WIDTH) begin
                m_rx[d][m_cnt[d]] <= si[d];
                m_cnt[d]          <= m_cnt[d] + 1;
                if (m_cnt[d] + 1 == FL) m_st[d] <= M_DONE;
              end else begin
                m_pe[d] <= si[d] ^ (^m_rx[d]);
                m_st[d] <= M_DONE;
              end
            end
          end
          default: begin
            m_st[d]   <= M_IDLE;
            m_hold[d] <= exp_po(d);
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cyc_po%0d", d),    32'(po[d]),  32'(exp_po(d)));
        check($sformatf("cyc_so%0d", d),    32'(so[d]),  32'(exp_so(d)));
        check($sformatf("cyc_ready%0d", d), 32'(rdy[d]), 32'(m_st[d] == M_IDLE));
        check($sformatf("cyc_busy%0d", d),  32'(bsy[d]), 32'(m_st[d] == M_BUSY));
        check($sformatf("cyc_done%0d", d),  32'(dn[d]),  32'(m_st[d] == M_DONE));
        check($sformatf("cyc_cnt%0d", d),   32'(cnt[d]), 32'(m_cnt[d]));
        check($sformatf("cyc_perr%0d", d),  32'(pe[d]),  32'(m_pe[d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input logic [WIDTH-1:0] w);
    pin   = w;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges after the START edge until done is visible (bounded).
  task automatic run_to_done(output int n);
    n = 0;
    while (!dn[0] && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(rdy), 32'h3);
    check({tag, "_busy"},  32'(bsy), 32'h0);
    check({tag, "_done"},  32'(dn),  32'h0);
    check({tag, "_so"},    32'(so),  32'h0);
    check({tag, "_perr"},  32'(pe),  32'h0);
    check({tag, "_po0"},   32'(po[0]), 32'h0);
    check({tag, "_po1"},   32'(po[1]), 32'h0);
    check({tag, "_cnt0"},  32'(cnt[0]), 32'h0);
    check({tag, "_cnt1"},  32'(cnt[1]), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int strobes;
    int c;
    rst = 1'b1; start = 1'b0; abort = 1'b0; shift_en = 1'b0;
    pin = '0; lb = 2'b00; cv = 2'b00; flip = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst    = 1'b0;
    chk_en = 1'b1;
    tick();

    // 1: loopback, DONE visible 15 edges after the START edge (cycle 16
    //    counting the START cycle as cycle 1), word returns unchanged.
    lb = 2'b11; shift_en = 1'b1;
    start_frame(15'h5A3C);
    run_to_done(n);
    check("t1_latency", 32'(n), 32'(FL));
    check("t1_po_lsb", 32'(po[0]), 32'h5A3C);
    check("t1_po_msb", 32'(po[1]), 32'h5A3C);
    check("t1_cnt", 32'(cnt[0]), 32'd15);
    tick();
    check("t1_ready_after", 32'(rdy[0]), 32'd1);

    // 2: constant 1 in, zero word out, MSB first.
    lb = 2'b00; cv = 2'b11;
    start_frame(15'h0000);
    n = 0;
    while (!dn[1] && n < 200) begin
      if (bsy[1] && cnt[1] < WIDTH) check("t2_so_msb", 32'(so[1]), 32'd0);
      tick();
      n++;
    end
    check("t2_po_msb", 32'(po[1]), 32'h7FFF);
    check("t2_po_lsb", 32'(po[0]), 32'h7FFF);
    tick();

    // 3: strobe every third cycle.
    lb = 2'b11; shift_en = 1'b0;
    start_frame(15'h1234);
    strobes = 0;
    c = 0;
    while (!dn[0] && c < 300) begin
      shift_en = (c % 3 == 2);
      tick();
      if (shift_en) begin
        strobes++;
        check("t3_cnt", 32'(cnt[0]), 32'((strobes > WIDTH) ? WIDTH : strobes));
      end
      c++;
    end
    check("t3_strobes", 32'(strobes), 32'(FL));
    check("t3_po", 32'(po[0]), 32'h1234);
    shift_en = 1'b1;
    tick();

    // 4: abort at bit_cnt 7, then a fresh frame.
    start_frame(15'h7E81);
    n = 0;
    while (cnt[0] != 4'd7 && n < 50) begin
      tick();
      n++;
    end
    check("t4_reach7", 32'(cnt[0]), 32'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_ready", 32'(rdy[0]), 32'd1);
    check("t4_busy", 32'(bsy[0]), 32'd0);
    check("t4_po", 32'(po[0]), 32'h0);
    check("t4_cnt", 32'(cnt[0]), 32'd0);
    repeat (3) begin
      tick();
      check("t4_no_done", 32'(dn[0]), 32'd0);
    end
    start_frame(15'h0F0F);
    run_to_done(n);
    check("t4_restart_latency", 32'(n), 32'(FL));
    check("t4_restart_po", 32'(po[0]), 32'h0F0F);
    tick();

    // 5: START while busy and during DONE is ignored; then reset mid-frame.
    start_frame(15'h3333);
    repeat (4) tick();
    pin = 15'h4444; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_start_busy", 32'(bsy[0]), 32'd1);
    check("t5_busy_start_cnt", 32'(cnt[0]), 32'd5);
    run_to_done(n);
    pin = 15'h4444; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_done_start_ready", 32'(rdy[0]), 32'd1);
    check("t5_done_start_po", 32'(po[0]), 32'h3333);
    tick();
    check("t5_not_queued", 32'(bsy[0]), 32'd0);
    start_frame(15'h5555);
    n = 0;
    while (cnt[0] != 4'd5 && n < 50) begin
      tick();
      n++;
    end
    check("t5_reach5", 32'(cnt[0]), 32'd5);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_async_rst");
    #1;
    rst = 1'b0;
    tick();

`ifdef FRAME_PARITY_EN
    // 6: parity slot, clean and with the received parity bit inverted.
    lb = 2'b11; flip = 1'b0;
    start_frame(15'h0001);
    n = 0;
    while (!dn[0] && n < 200) begin
      if (bsy[0] && cnt[0] == 4'(WIDTH)) check("t6_par_bit", 32'(so[0]), 32'd1);
      tick();
      n++;
    end
    check("t6_latency", 32'(n), 32'd16);
    check("t6_perr_clean", 32'(pe[0]), 32'd0);
    check("t6_po", 32'(po[0]), 32'h0001);
    tick();
    flip = 1'b1;
    start_frame(15'h0001);
    run_to_done(n);
    check("t6_perr_flip", 32'(pe[0]), 32'd1);
    check("t6_perr_flip_msb", 32'(pe[1]), 32'd1);
    check("t6_po_flip", 32'(po[0]), 32'h0001);
    flip = 1'b0;
    tick();
`endif

    repeat (2) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
